// File: rtl/disp_seq_pkg.sv
// Shared types, segment constants and hex-to-7-segment decode for the
// display sequencer.
package disp_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DP    = 8'h80;

  // Active-high segments, bit0=a .. bit6=g; dp (bit7) is left clear here.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'h0: seg = 8'h3F;
      4'h1: seg = 8'h06;
      4'h2: seg = 8'h5B;
      4'h3: seg = 8'h4F;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'h6D;
      4'h6: seg = 8'h7D;
      4'h7: seg = 8'h07;
      4'h8: seg = 8'h7F;
      4'h9: seg = 8'h6F;
      4'hA: seg = 8'h77;
      4'hB: seg = 8'h7C;
      4'hC: seg = 8'h39;
      4'hD: seg = 8'h5E;
      4'hE: seg = 8'h79;
      default: seg = 8'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Display-tick prescaler: counts 0..DIV-1 and flags the last count as a
// one-cycle tick. clr restarts the phase so a new playout starts aligned.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] r_count;

  // Modulo-DIV counter, restarted by clr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr || (r_count == LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 16'd1;
    end
  end

  assign tick = (r_count == LAST);

endmodule

// File: rtl/disp_seq_ctrl.sv
// Buffers up to DEPTH hex digits and plays them out on a 7-segment display:
// each digit is shown for HOLD_TICKS ticks followed by a one-tick blank gap.
// The last digit of a playout carries the decimal point.
module disp_seq_ctrl
  import disp_seq_pkg::*;
#(
  parameter int DIV        = 4,
  parameter int HOLD_TICKS = 3,
  parameter int DEPTH      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_data,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] seg_out
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [7:0]         r_hold;
  logic               r_busy;
  logic               r_done;
  logic [7:0]         r_seg;
  logic [3:0]         r_buf [DEPTH];

  logic               w_tick;
  logic               w_start_ok;
  logic               w_wr_ok;
  logic [PTR_W-1:0]   w_next_ptr;
  logic               w_cur_last;
  logic               w_next_last;

  // Start beats a simultaneous write; an empty buffer cannot be played.
  assign w_start_ok  = (r_state == ST_IDLE) && start && (r_cnt != '0);
  assign w_wr_ok     = (r_state == ST_IDLE) && wr_en && !start &&
                       (r_cnt < CNT_W'(DEPTH));
  assign w_next_ptr  = r_rd_ptr + PTR_W'(1);
  assign w_cur_last  = ({1'b0, r_rd_ptr}   == (r_cnt - CNT_W'(1)));
  assign w_next_last = ({1'b0, w_next_ptr} == (r_cnt - CNT_W'(1)));

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (w_start_ok),
    .tick  (w_tick)
  );

  // Digit storage; contents are only meaningful below r_cnt, so no reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_buf[r_cnt[PTR_W-1:0]] <= wr_data;
    end
  end

  // Sequencer FSM; outputs are registered from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_rd_ptr <= '0;
      r_hold   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_seg    <= SEG_DASH;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_state  <= ST_SHOW;
            r_rd_ptr <= '0;
            r_hold   <= '0;
            r_busy   <= 1'b1;
            r_seg    <= hex_to_seg(r_buf[0]) |
                        ((r_cnt == CNT_W'(1)) ? SEG_DP : 8'h00);
          end else if (w_wr_ok) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (w_tick) begin
            if (r_hold == HOLD_LAST) begin
              r_state <= ST_GAP;
              r_seg   <= SEG_BLANK;
            end else begin
              r_hold <= r_hold + 8'd1;
            end
          end
        end
        ST_GAP: begin
          if (w_tick) begin
            if (w_cur_last) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_seg   <= SEG_DASH;
            end else begin
              r_state  <= ST_SHOW;
              r_rd_ptr <= w_next_ptr;
              r_hold   <= '0;
              r_seg    <= hex_to_seg(r_buf[w_next_ptr]) |
                          (w_next_last ? SEG_DP : 8'h00);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_seg   <= SEG_DASH;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign seg_out = r_seg;

endmodule
